// File: rtl/serial_pkg.sv
// serial_pkg: shared types and helpers for the serial transmit/receive blocks
package serial_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic DEFAULT_IDLE_BIT = 1'b0;
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake plus serial output bundle of the serializer
interface piso_serializer_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] data_in;
  logic load_valid;
  logic load_ready;
  logic q;
  logic q_valid;
  logic sof;
  logic eof;
  logic busy;
  modport master(output data_in, load_valid, input load_ready, q, q_valid, sof, eof, busy);
  modport slave(input data_in, load_valid, output load_ready, q, q_valid, sof, eof, busy);
endinterface

// File: rtl/shift_register.sv
// shift_register: serial-in shift register chain, q is d delayed by DEPTH edges
module shift_register #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] r;
  // shift d in at the low end, oldest bit leaves at the top
  always_ff @(posedge clk) r <= rst ? '0 : {r[DEPTH-2:0], d};
  assign q = r[DEPTH-1];
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out transmitter with valid/ready load and framing strobes
module piso_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = 4,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input logic clk,
  input logic rst,
  piso_serializer_if.slave bus
);
  localparam int CW  = cnt_width(WIDTH);
  localparam int OUT = MSB_FIRST ? WIDTH - 1 : 0;
  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             last, xfer;
  // next state: a transfer reloads the word, otherwise shift until the last bit leaves
  always_comb begin
    last           = cnt == CW'(WIDTH - 1);
    bus.load_ready = !rst && (state == IDLE || last);
    xfer           = bus.load_ready && bus.load_valid;
    state_n        = (xfer || (state == SHIFT && !last)) ? SHIFT : IDLE;
    cnt_n          = (!xfer && state == SHIFT && !last) ? cnt + 1'b1 : '0;
    sr_n           = xfer ? bus.data_in : MSB_FIRST ? {sr[WIDTH-2:0], IDLE_BIT} : {IDLE_BIT, sr[WIDTH-1:1]};
  end
  // state, shift register and bit counter
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    sr    <= rst ? '0 : sr_n;
    cnt   <= rst ? '0 : cnt_n;
  end
  assign bus.q       = (state == SHIFT) ? sr[OUT] : IDLE_BIT;
  assign bus.q_valid = state == SHIFT;
  assign bus.busy    = state == SHIFT;
  assign bus.sof     = state == SHIFT && cnt == '0;
  assign bus.eof     = state == SHIFT && last;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table vectors, LSB-first sequence and randomized model check with chain
module tb_piso_serializer;
  localparam int W = 4;
  localparam int D = 3;
  logic clk = 1'b0, rst = 1'b1, lv = 1'b0, sr_q;
  logic [W-1:0] din = '0;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  piso_serializer_if #(.WIDTH(W)) bm();
  piso_serializer_if #(.WIDTH(W)) bl();
  assign bm.data_in = din;
  assign bm.load_valid = lv;
  assign bl.data_in = din;
  assign bl.load_valid = lv;
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (.clk(clk), .rst(rst), .bus(bm));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bl));
  shift_register #(.DEPTH(D)) chain (.clk(clk), .rst(rst), .d(bm.q), .q(sr_q));
  typedef struct packed {
    logic r;
    logic v;
    logic [W-1:0] d;
    logic rdy;
    logic [3:0] o;
  } vec_t;
  vec_t tab[$];
  function automatic void add(logic r, logic v, logic [W-1:0] d, logic rdy, logic [3:0] o);
    tab.push_back('{r: r, v: v, d: d, rdy: rdy, o: o});
  endfunction
  task automatic check(string n, logic [7:0] a, logic [7:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] got, word;
    logic er, eqm, eql;
    logic [3:0] fl;
    logic hq[$];
    int n, pos;
    add(1, 0, 0, 0, 4'b0000);
    add(1, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 1, 4'b0000);
    add(0, 1, 4'b1011, 1, 4'b1110); add(0, 0, 0, 0, 4'b0100); add(0, 0, 0, 0, 4'b1100);
    add(0, 0, 0, 0, 4'b1101); add(0, 0, 0, 1, 4'b0000);
    add(0, 1, 4'b1011, 1, 4'b1110); add(0, 1, 4'b0110, 0, 4'b0100); add(0, 1, 4'b0110, 0, 4'b1100);
    add(0, 1, 4'b0110, 0, 4'b1101); add(0, 1, 4'b0110, 1, 4'b0110); add(0, 0, 0, 0, 4'b1100);
    add(0, 0, 0, 0, 4'b1100); add(0, 0, 0, 0, 4'b0101); add(0, 0, 0, 1, 4'b0000);
    add(0, 1, 4'b0001, 1, 4'b0110); add(0, 1, 4'b1111, 0, 4'b0100); add(0, 1, 4'b1111, 0, 4'b0100);
    add(0, 1, 4'b1111, 0, 4'b1101); add(0, 1, 4'b1111, 1, 4'b1110); add(0, 0, 0, 0, 4'b1100);
    add(0, 0, 0, 0, 4'b1100); add(0, 0, 0, 0, 4'b1101); add(0, 0, 0, 1, 4'b0000);
    add(0, 1, 4'b1100, 1, 4'b1110); add(0, 0, 0, 0, 4'b1100); add(1, 0, 0, 0, 4'b0000);
    add(0, 1, 4'b1010, 1, 4'b1110); add(0, 0, 0, 0, 4'b0100); add(0, 0, 0, 0, 4'b1100);
    add(0, 0, 0, 0, 4'b0101); add(0, 0, 0, 1, 4'b0000);
    add(1, 1, 4'b1111, 0, 4'b0000); add(0, 0, 0, 1, 4'b0000);
    foreach (tab[i]) begin
      rst = tab[i].r; lv = tab[i].v; din = tab[i].d;
      #1;
      check($sformatf("vec%0d ready", i), {7'd0, bm.load_ready}, {7'd0, tab[i].rdy});
      @(posedge clk); #1;
      check($sformatf("vec%0d out", i), {3'd0, bm.q, bm.q_valid, bm.sof, bm.eof, bm.busy},
            {3'd0, tab[i].o, tab[i].o[2]});
    end
    rst = 1'b0; lv = 1'b1; din = 4'b1011;
    #1;
    check("lsb ready", {7'd0, bl.load_ready}, 8'd1);
    @(posedge clk); #1;
    lv = 1'b0;
    check("lsb sof", {7'd0, bl.sof}, 8'd1);
    got = '0; n = 0;
    for (int c = 0; c < 8; c++) begin
      if (bl.q_valid) begin
        if (n < W) got[n] = bl.q;
        n++;
        if (bl.eof) break;
      end
      @(posedge clk); #1;
    end
    check("lsb eof", {7'd0, bl.eof}, 8'd1);
    check("lsb bits", {4'd0, got}, 8'b0000_1011);
    check("lsb count", 8'(n), 8'd4);
    @(posedge clk); #1;
    pos = -1; word = '0;
    for (int c = 0; c < 400; c++) begin
      rst = (c == 0) || ($urandom_range(0, 39) == 0);
      lv = $urandom_range(0, 9) < 7;
      din = W'($urandom);
      #1;
      er = !rst && (pos < 0 || pos == W - 1);
      check("rnd ready m", {7'd0, bm.load_ready}, {7'd0, er});
      check("rnd ready l", {7'd0, bl.load_ready}, {7'd0, er});
      if (rst) begin
        pos = -1; word = '0; hq.delete();
      end else if (er && lv) begin
        word = din; pos = 0;
      end else if (pos >= 0) begin
        pos = (pos == W - 1) ? -1 : pos + 1;
      end
      @(posedge clk); #1;
      eqm = (pos < 0) ? 1'b0 : word[W-1-pos];
      eql = (pos < 0) ? 1'b0 : word[pos];
      fl = {pos >= 0, pos == 0, pos == W - 1, pos >= 0};
      check("rnd out m", {3'd0, bm.q, bm.q_valid, bm.sof, bm.eof, bm.busy}, {3'd0, eqm, fl});
      check("rnd out l", {3'd0, bl.q, bl.q_valid, bl.sof, bl.eof, bl.busy}, {3'd0, eql, fl});
      hq.push_back(eqm);
      check("chain q", {7'd0, sr_q}, {7'd0, (hq.size() > D) ? hq[hq.size()-1-D] : 1'b0});
      if (hq.size() > 8) void'(hq.pop_front());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
